// File: rtl/execute_mul_pipe_if.sv
// execute_mul_pipe_if: issue and writeback handshake bundle for the Y-slot multiply unit
interface execute_mul_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int FU_W   = 2
);
  logic [FU_W-1:0]   is_functionalunit;
  logic [DATA_W-1:0] is_rega;
  logic [DATA_W-1:0] is_regb;
  logic [REG_W-1:0]  is_regdest;
  logic [1:0]        is_mode;
  logic              is_ready;
  logic              wb_ready;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_regdest;
  logic              wb_writereg;
  logic [DATA_W-1:0] wb_wbvalue;
  logic              wb_overflow;
  modport master (
    output is_functionalunit, is_rega, is_regb, is_regdest, is_mode, wb_ready,
    input  is_ready, wb_valid, wb_regdest, wb_writereg, wb_wbvalue, wb_overflow
  );
  modport slave (
    input  is_functionalunit, is_rega, is_regb, is_regdest, is_mode, wb_ready,
    output is_ready, wb_valid, wb_regdest, wb_writereg, wb_wbvalue, wb_overflow
  );
endinterface

// File: rtl/execute_mul_pipe.sv
// execute_mul_pipe: 4-stage sign/magnitude integer multiplier with signed/unsigned, low/high modes
module execute_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int FU_W   = 2,
  parameter int FU_ID  = 3
) (
  input logic clock,
  input logic reset,
  execute_mul_pipe_if.slave bus
);
  localparam int W = DATA_W;
  logic stall, accept, neg_in;
  logic v0, v1, v2, v3;
  logic n0, n1, n2;
  logic [1:0] m0, m1, m2;
  logic [REG_W-1:0] rd0, rd1, rd2, rd3;
  logic [W-1:0] a0, b0, ma1, mb1, mag_a, mag_b, val3, val_n;
  logic [2*W-1:0] p2, prod, pp;
  logic [W:0] top;
  logic ovf3, ovf_n;
  assign stall = bus.wb_valid & ~bus.wb_ready;
  assign bus.is_ready = ~stall;
  assign accept = bus.is_ready & (bus.is_functionalunit == FU_W'(FU_ID));
  // zero operands never produce a negative result, so -0 cannot appear in high-half mode
  assign neg_in = ~bus.is_mode[0] & (bus.is_rega[W-1] ^ bus.is_regb[W-1]) & (|bus.is_rega) & (|bus.is_regb);
  assign mag_a = (~m0[0] & a0[W-1]) ? -a0 : a0;
  assign mag_b = (~m0[0] & b0[W-1]) ? -b0 : b0;
  assign prod = (2*W)'(ma1) * (2*W)'(mb1);
  assign pp = n2 ? -p2 : p2;
  assign top = pp[2*W-1:W-1];
  assign val_n = m2[1] ? pp[2*W-1:W] : pp[W-1:0];
  assign ovf_n = m2[1] ? 1'b0 : m2[0] ? |pp[2*W-1:W] : ~(&top | ~|top);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {v0, v1, v2, v3, n0, n1, n2, m0, m1, m2} <= '0;
      {rd0, rd1, rd2, rd3, a0, b0, ma1, mb1, p2, val3, ovf3} <= '0;
    end else if (!stall) begin
      v0 <= accept;
      a0 <= bus.is_rega;
      b0 <= bus.is_regb;
      m0 <= bus.is_mode;
      rd0 <= bus.is_regdest;
      n0 <= neg_in;
      v1 <= v0;
      ma1 <= mag_a;
      mb1 <= mag_b;
      m1 <= m0;
      rd1 <= rd0;
      n1 <= n0;
      v2 <= v1;
      p2 <= prod;
      m2 <= m1;
      rd2 <= rd1;
      n2 <= n1;
      v3 <= v2;
      rd3 <= v2 ? rd2 : '0;
      val3 <= v2 ? val_n : '0;
      ovf3 <= v2 & ovf_n;
    end
  assign bus.wb_valid = v3;
  assign bus.wb_regdest = rd3;
  assign bus.wb_wbvalue = val3;
  assign bus.wb_overflow = ovf3;
  assign bus.wb_writereg = v3 & ~ovf3;
endmodule

// File: tb/tb_execute_mul_pipe.sv
// tb_execute_mul_pipe: directed scenarios with hand-computed results for the multiply pipe
module tb_execute_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [39:0] got;
  execute_mul_pipe_if #(.DATA_W(32), .REG_W(5), .FU_W(2)) bus ();
  execute_mul_pipe #(.DATA_W(32), .REG_W(5), .FU_W(2), .FU_ID(3)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // {valid, regdest, writereg, overflow, value}
  assign got = {bus.wb_valid, bus.wb_regdest, bus.wb_writereg, bus.wb_overflow, bus.wb_wbvalue};
  task automatic drive(input logic [1:0] fu, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [1:0] m);
    bus.is_functionalunit = fu;
    bus.is_rega = a;
    bus.is_regb = b;
    bus.is_regdest = rd;
    bus.is_mode = m;
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    #1;
    vectors++;
    if (got !== 40'h0 || bus.is_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got %h rdy %b want 0 rdy 1", got, bus.is_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_latency;
    drive(3, 32'd7, 32'hFFFFFFFD, 5'd9, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive(0, 0, 0, 0, 0);
      vectors++;
      if (got[39] !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early edge%0d: got valid %b want 0", i, got[39]);
      end
    end
    tick();
    vectors++;
    if (got !== {1'b1, 5'd9, 1'b1, 1'b0, 32'hFFFFFFEB}) begin
      miscompares++;
      $display("FAIL signed_low: got %h want %h", got, {1'b1, 5'd9, 1'b1, 1'b0, 32'hFFFFFFEB});
    end
    tick();
    vectors++;
    if (got !== 40'h0) begin
      miscompares++;
      $display("FAIL after_single: got %h want 0", got);
    end
  endtask
  task automatic test_modes;
    logic [31:0] a [5] = '{32'h00010000, 32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] b [5] = '{32'h00010000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000001};
    logic [1:0]  m [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [39:0] e [5] = '{{1'b1, 5'd1, 1'b0, 1'b1, 32'h00000000},
                           {1'b1, 5'd2, 1'b0, 1'b1, 32'h00000000},
                           {1'b1, 5'd3, 1'b1, 1'b0, 32'h40000000},
                           {1'b1, 5'd4, 1'b1, 1'b0, 32'h40000000},
                           {1'b1, 5'd5, 1'b1, 1'b0, 32'hFFFFFFFF}};
    for (int i = 0; i < 5; i++) begin
      drive(3, a[i], b[i], 5'(i + 1), m[i]);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      tick();
      vectors++;
      if (got !== e[i]) begin
        miscompares++;
        $display("FAIL mode_vec%0d: got %h want %h", i, got, e[i]);
      end
      tick();
    end
  endtask
  task automatic test_back_to_back;
    logic [1:0]  fu [4] = '{2'd3, 2'd3, 2'd1, 2'd3};
    logic [31:0] a [4] = '{32'd2, 32'd0, 32'd9, 32'hFFFFFFFF};
    logic [31:0] b [4] = '{32'd3, 32'hFFFFFFFB, 32'd9, 32'hFFFFFFFF};
    logic [1:0]  m [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
    logic [39:0] e [4] = '{{1'b1, 5'd1, 1'b1, 1'b0, 32'd6},
                           {1'b1, 5'd2, 1'b1, 1'b0, 32'd0},
                           40'h0,
                           {1'b1, 5'd4, 1'b1, 1'b0, 32'hFFFFFFFE}};
    for (int i = 0; i < 4; i++) begin
      drive(fu[i], a[i], b[i], 5'(i + 1), m[i]);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (got !== e[j]) begin
        miscompares++;
        $display("FAIL b2b_res%0d: got %h want %h", j, got, e[j]);
      end
      tick();
    end
  endtask
  task automatic test_backpressure;
    logic [39:0] e [4];
    for (int i = 0; i < 4; i++) e[i] = {1'b1, 5'(10 + i), 1'b1, 1'b0, 32'(10 * (i + 1))};
    for (int i = 0; i < 4; i++) begin
      drive(3, 32'(i + 1), 32'd10, 5'(10 + i), 2'b00);
      tick();
    end
    bus.wb_ready = 1'b0;
    drive(3, 32'd99, 32'd99, 5'd31, 2'b00);
    #1;
    vectors++;
    if (got !== e[0] || bus.is_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_enter: got %h rdy %b want %h rdy 0", got, bus.is_ready, e[0]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (got !== e[0] || bus.is_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got %h rdy %b want %h rdy 0", k, got, bus.is_ready, e[0]);
      end
    end
    drive(0, 0, 0, 0, 0);
    bus.wb_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      vectors++;
      if (got !== e[j]) begin
        miscompares++;
        $display("FAIL bp_drain%0d: got %h want %h", j, got, e[j]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (got !== 40'h0) begin
        miscompares++;
        $display("FAIL bp_extra%0d: got %h want 0", k, got);
      end
    end
  endtask
  task automatic test_reset_midflight;
    drive(3, 32'd5, 32'd6, 5'd7, 2'b00);
    tick();
    drive(3, 32'd8, 32'd9, 5'd8, 2'b00);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    bus.wb_ready = 1'b0;
    vectors++;
    if (got !== {1'b1, 5'd7, 1'b1, 1'b0, 32'd30}) begin
      miscompares++;
      $display("FAIL rst_pre: got %h want %h", got, {1'b1, 5'd7, 1'b1, 1'b0, 32'd30});
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (got !== 40'h0 || bus.is_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async: got %h rdy %b want 0 rdy 1", got, bus.is_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.wb_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (got !== 40'h0) begin
        miscompares++;
        $display("FAIL rst_stale%0d: got %h want 0", k, got);
      end
    end
    drive(3, 32'hFFFFFFFC, 32'd5, 5'd12, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    vectors++;
    if (got[39] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_new_early: got valid %b want 0", got[39]);
    end
    tick();
    vectors++;
    if (got !== {1'b1, 5'd12, 1'b1, 1'b0, 32'hFFFFFFFF}) begin
      miscompares++;
      $display("FAIL rst_new_op: got %h want %h", got, {1'b1, 5'd12, 1'b1, 1'b0, 32'hFFFFFFFF});
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    bus.wb_ready = 1'b1;
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/execute_mul_pipe.md
Name: execute_mul_pipe

Overview:
Parametrised, fully pipelined integer multiply execute unit for the Y issue slot.
- Accepts one operation per cycle from issue when the functional-unit code matches FU_ID.
- Computes a 2*DATA_W product via sign/magnitude decomposition over 4 registered stages.
- Delivers a DATA_W writeback value with valid, overflow and write-enable qualifiers.
- Adds signed/unsigned and low/high-half modes, plus writeback backpressure.

Parameters:
DATA_W, 32, operand and writeback width (>= 8)
REG_W, 5, destination register index width
FU_W, 2, functional-unit code width
FU_ID, 3, functional-unit code that selects this block

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all pipeline state
is_functionalunit  in  FU_W  issue functional-unit code; op present when == FU_ID
is_rega  in  DATA_W  operand A
is_regb  in  DATA_W  operand B
is_regdest  in  REG_W  destination register
is_mode  in  2  bit0: 1=unsigned, 0=signed; bit1: 1=return high half, 0=low half
is_ready  out  1  block can accept an op this cycle
wb_ready  in  1  writeback consumes wb_* this cycle
wb_valid  out  1  wb_* carry a completed op
wb_regdest  out  REG_W  destination of completed op
wb_writereg  out  1  register write enable (valid and no overflow)
wb_wbvalue  out  DATA_W  result
wb_overflow  out  1  low-half result not representable

Behaviour:
- Reset: every stage valid bit and payload register = 0. Outputs: wb_valid=0, wb_regdest=0, wb_writereg=0, wb_wbvalue=0, wb_overflow=0, is_ready=1. Reset asserted mid-operation discards all in-flight ops; no partial writeback.
- Stall: stall = wb_valid & ~wb_ready. is_ready = ~stall, combinational. While stall=1 all four stages hold, including payload and valid bits.
- Accept: accept = is_ready & (is_functionalunit == FU_ID). Non-matching codes insert a bubble (valid=0). Operand and payload registers of bubble stages are don't-care, but wb_* payload must read 0 whenever wb_valid=0.
- Stage Y0 (accept edge): capture operands, mode and regdest.
  - neg = signed mode & (sign(A) XOR sign(B)) & A!=0 & B!=0.
  - Zero operand forces neg=0.
- Stage Y1: magnitudes. In signed mode, a negative operand becomes its two's complement as a DATA_W unsigned value. -2^(DATA_W-1) yields 2^(DATA_W-1), which is correct. Unsigned mode passes operands through.
- Stage Y2: 2*DATA_W unsigned product of the magnitudes.
- Stage Y3 (outputs): P = neg ? two's complement of product (2*DATA_W wide) : product.
  - wb_wbvalue = mode[1] ? P[2W-1:W] : P[W-1:0].
  - Overflow, high-half modes: always 0.
  - Overflow, unsigned low: P[2W-1:W] != 0.
  - Overflow, signed low: P[2W-1:W-1] is not all-0 and not all-1.
  - wb_writereg = wb_valid & ~wb_overflow. wb_wbvalue still carries the low half on overflow.
- Latency: exactly 4 cycles from accept edge to wb_valid with no stall. Each stall cycle adds one cycle. Throughput: 1 op/cycle. Ops complete in issue order.
- Simultaneous accept and drain in the same cycle with wb_ready=1: both occur, no bubble.
- While stall=1 an op presented at issue is not accepted. Issue must hold it.

Test Plan:
- Single-op latency and signed low: DATA_W=32, FU_ID=3, mode=00, A=7, B=0xFFFFFFFD, wb_ready=1. Expect wb_valid exactly 4 cycles after accept, wbvalue=0xFFFFFFEB, writereg=1, overflow=0, regdest echoed.
- Unsigned low overflow: mode=01, A=B=0x00010000. Expect wbvalue=0x00000000, overflow=1, writereg=0, wb_valid=1.
- Most-negative signed: A=B=0x80000000. With mode=00 expect overflow=1, writereg=0. With mode=10 expect wbvalue=0x40000000, writereg=1. With mode=11 expect 0x40000000. Separately, A=0xFFFFFFFF, B=1, mode=10: expect 0xFFFFFFFF.
- Back-to-back with bubbles: 4 consecutive ops (2*3, 0*-5, fu=1 bubble, 0xFFFFFFFF*0xFFFFFFFF unsigned high). Expect in-order results 6, 0 (writereg=1), a bubble cycle, then 0xFFFFFFFE, with no gaps between valid ops.
- Backpressure: fill the pipe with 4 ops, then drop wb_ready for 3 cycles. Expect is_ready=0 and wb_* frozen on the first result, with no op lost or duplicated. On wb_ready=1, the remaining results appear on consecutive cycles.
- Reset mid-flight: assert reset 2 cycles after accepting 2 ops. Expect wb_* all 0 immediately (asynchronous) and is_ready=1. No stale result appears after reset release. A new op completes 4 cycles after its accept.
